// File: rtl/dht_reader.sv
`default_nettype none
// ============================================================================
// Module   : dht_reader
// Brief    : Single-wire DHT11/DHT22 reader. It drives the bus open-drain,
//            checks the checksum and holds off between measurements.
//            Optional macro DHT_READER_AUTO_POLL_EN adds self-timed polling.
// Revision : 1.0 - initial release
// ============================================================================
module dht_reader #(
    parameter int CLK_HZ          = 50000000,
    parameter int START_LOW_US    = 18000,
    parameter int RESP_TIMEOUT_US = 100,
    parameter int BIT_THRESH_US   = 50,
    parameter int HOLDOFF_MS      = 1000
`ifdef DHT_READER_AUTO_POLL_EN
    ,
    parameter int POLL_MS         = 2000
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        START,
    input  logic        MODE,
    inout  wire         DHT_DATA,
    output logic [15:0] HUM,
    output logic [15:0] TEMP,
    output logic [39:0] RAW,
    output logic        BUSY,
    output logic        DONE,
    output logic        VALID,
    output logic [1:0]  ERR
);

    localparam int c_CYC_PER_US = CLK_HZ / 1000000;
    localparam int c_START_CYC  = START_LOW_US * c_CYC_PER_US;
    localparam int c_RESP_CYC   = RESP_TIMEOUT_US * c_CYC_PER_US;
    localparam int c_THRESH_CYC = BIT_THRESH_US * c_CYC_PER_US;
    localparam int c_HOLD_CYC   = HOLDOFF_MS * 1000 * c_CYC_PER_US;
    localparam int c_MAX_A      = (c_START_CYC > c_RESP_CYC) ? c_START_CYC : c_RESP_CYC;
    localparam int c_MAX_CYC    = (c_MAX_A > c_HOLD_CYC) ? c_MAX_A : c_HOLD_CYC;
    localparam int c_CNT_W      = $clog2(c_MAX_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_START_END = c_CNT_W'(c_START_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RESP_END  = c_CNT_W'(c_RESP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_END  = c_CNT_W'(c_HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_THRESH_V  = c_CNT_W'(c_THRESH_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_FINISH, S_HOLDOFF
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [5:0]          r_idx;
    logic [39:0]         r_shift;
    logic                r_mode;
    logic                r_drive_low;
    logic                r_sync1, r_sync2, r_sync_prev;
    logic [15:0]         r_hum, r_temp;
    logic [39:0]         r_raw;
    logic                r_busy, r_done, r_valid;
    logic [1:0]          r_err;

    logic                w_start;
    logic                w_fall;
    logic                w_timeout;
    logic [7:0]          w_sum;
    logic                w_cksum_ok;
    logic [15:0]         w_mag;
    logic [15:0]         w_temp22;

    assign DHT_DATA = r_drive_low ? 1'b0 : 1'bz;

    assign HUM   = r_hum;
    assign TEMP  = r_temp;
    assign RAW   = r_raw;
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign VALID = r_valid;
    assign ERR   = r_err;

    // Our own start pulse is still in the synchroniser after release, so the
    // sensor response is recognised by a high-to-low edge rather than a level.
    assign w_fall     = r_sync_prev & ~r_sync2;
    assign w_timeout  = (r_cnt == c_RESP_END);
    assign w_sum      = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
    assign w_cksum_ok = (w_sum == r_shift[7:0]);
    assign w_mag      = {1'b0, r_shift[22:16], r_shift[15:8]};
    assign w_temp22   = r_shift[23] ? (16'd0 - w_mag) : w_mag;

`ifdef DHT_READER_AUTO_POLL_EN
    localparam int c_POLL_CYC = POLL_MS * 1000 * c_CYC_PER_US;
    localparam int c_POLL_W   = $clog2(c_POLL_CYC + 1);
    localparam logic [c_POLL_W-1:0] c_POLL_END = c_POLL_W'(c_POLL_CYC - 1);

    logic [c_POLL_W-1:0] r_poll_cnt;
    logic                r_poll_req;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_poll_cnt <= '0;
            r_poll_req <= 1'b0;
        end else begin
            r_poll_req <= 1'b0;
            if (r_state != S_IDLE || START) begin
                r_poll_cnt <= '0;
            end else if (EN) begin
                if (r_poll_cnt == c_POLL_END) begin
                    r_poll_cnt <= '0;
                    r_poll_req <= 1'b1;
                end else begin
                    r_poll_cnt <= r_poll_cnt + c_POLL_W'(1);
                end
            end
        end
    end

    assign w_start = START | r_poll_req;
`else
    assign w_start = START;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= DHT_DATA;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_mode      <= 1'b0;
            r_drive_low <= 1'b0;
            r_hum       <= '0;
            r_temp      <= '0;
            r_raw       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= '0;
        end else begin
            r_done <= 1'b0;
            if (EN) begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_state     <= S_START_LOW;
                        r_cnt       <= '0;
                        r_drive_low <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mode      <= MODE;
                    end
                    S_START_LOW: if (r_cnt == c_START_END) begin
                        r_state     <= S_RELEASE;
                        r_cnt       <= '0;
                        r_drive_low <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    S_RELEASE: if (w_fall) begin
                        r_state <= S_RESP_LOW;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_FINISH;
                        r_err   <= 2'd1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    S_RESP_LOW: if (r_sync2) begin
                        r_state <= S_RESP_HIGH;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_FINISH;
                        r_err   <= 2'd1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    S_RESP_HIGH: if (!r_sync2) begin
                        r_state <= S_BIT_LOW;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_FINISH;
                        r_err   <= 2'd1;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    S_BIT_LOW: if (r_sync2) begin
                        r_state <= S_BIT_HIGH;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_FINISH;
                        r_err   <= 2'd2;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    S_BIT_HIGH: if (!r_sync2) begin
                        r_shift <= {r_shift[38:0], (r_cnt > c_THRESH_V)};
                        r_cnt   <= '0;
                        if (r_idx == 6'd39) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= S_BIT_LOW;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_FINISH;
                        r_err   <= 2'd2;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    S_CHECK: begin
                        r_raw   <= r_shift;
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                        if (w_cksum_ok) begin
                            r_hum   <= r_shift[39:24];
                            r_temp  <= r_mode ? w_temp22 : r_shift[23:8];
                            r_valid <= 1'b1;
                            r_err   <= 2'd0;
                        end else begin
                            r_err <= 2'd3;
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_HOLDOFF;
                        r_cnt   <= '0;
                    end
                    S_HOLDOFF: if (r_cnt == c_HOLD_END) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dht_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht_reader
// Brief    : Self-checking bench for dht_reader with a behavioural sensor model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dht_reader;

    localparam int CLK_HZ   = 1000000;
    localparam int START_US = 1000;   // shortened start pulse keeps the run brief
    localparam int RESP_US  = 100;

    logic        clk;
    logic        rst_n, en, start, mode;
    wire         dht_bus;
    logic [15:0] hum, temp;
    logic [39:0] raw;
    logic        busy, done, valid;
    logic [1:0]  err;
    logic        sensor_low;

    int total, bad;
    int start_len, model_bit;
    bit model_abort;
    logic [15:0] exp_hum, exp_temp;

    assign dht_bus = sensor_low ? 1'b0 : 1'bz;
    pullup (dht_bus);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dht_reader #(
        .CLK_HZ(CLK_HZ), .START_LOW_US(START_US), .RESP_TIMEOUT_US(RESP_US),
        .BIT_THRESH_US(50), .HOLDOFF_MS(1)
    ) u_dut (
        .CLK(clk), .RST(rst_n), .EN(en), .START(start), .MODE(mode),
        .DHT_DATA(dht_bus), .HUM(hum), .TEMP(temp), .RAW(raw),
        .BUSY(busy), .DONE(done), .VALID(valid), .ERR(err)
    );

    // ---------------- sensor model ----------------
    task automatic drive(input bit lvl, input int n);
        if (model_abort) begin sensor_low = 1'b0; return; end
        sensor_low = !lvl;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (model_abort) begin sensor_low = 1'b0; return; end
        end
    endtask

    task automatic sensor_run(input logic [39:0] frame, input int stall_bit);
        int n;
        start_len = 0;
        model_bit = -1;
        n = 0;
        while (dht_bus !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
        while (dht_bus === 1'b0 && start_len < 20000) begin start_len++; @(negedge clk); end
        drive(1'b1, int'($urandom_range(40, 20)));
        drive(1'b0, 80);
        drive(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            model_bit = i;
            drive(1'b0, int'($urandom_range(55, 30)));
            if (i == stall_bit) begin drive(1'b1, 150); return; end
            drive(1'b1, frame[39-i] ? int'($urandom_range(75, 65)) : int'($urandom_range(32, 20)));
        end
        drive(1'b0, 50);
        drive(1'b1, 20);
        drive(1'b0, 20);   // stray pulse after the frame
        sensor_low = 1'b0;
    endtask

    // ---------------- host helpers ----------------
    task automatic pulse_start(input bit m);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic launch(input logic [39:0] f, input bit m, input int stall_bit);
        model_abort = 1'b0;
        fork
            sensor_run(f, stall_bit);
        join_none
        pulse_start(m);
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        ok = (done === 1'b1);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        ok = (busy === 1'b0);
        repeat (5) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sensor_low = 1'b0; model_abort = 1'b0;
        rst_n = 1'b0; en = 1'b1; start = 1'b0; mode = 1'b0;
        exp_hum = '0; exp_temp = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({hum, temp, raw, busy, done, valid, err} !== 77'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {hum, temp, raw, busy, done, valid, err});
        end
        total++;
        if (dht_bus !== 1'b1) begin bad++; $display("FAIL reset_bus: got %b want 1", dht_bus); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_response();
        int n, len;
        bit ok;
        pulse_start(1'b0);
        n = 0;
        while (dht_bus !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        len = 0;
        while (dht_bus === 1'b0 && len < 5000) begin len++; @(negedge clk); end
        total++;
        if (len != START_US) begin bad++; $display("FAIL noresp_start_len: got %0d want %0d", len, START_US); end
        n = 0;
        while (done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        total++;
        if (n != RESP_US) begin bad++; $display("FAIL noresp_done_delay: got %0d want %0d", n, RESP_US); end
        total++;
        if ({err, valid, hum, temp} !== {2'd1, 1'b0, exp_hum, exp_temp}) begin
            bad++; $display("FAIL noresp_result: got err=%0d valid=%b hum=%h temp=%h want err=1 valid=0 hum=%h temp=%h",
                            err, valid, hum, temp, exp_hum, exp_temp);
        end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL noresp_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_frame(input string name, input logic [39:0] f, input bit m,
                              input logic [1:0] want_err, input bit chk_len);
        bit ok;
        if (want_err == 2'd0) begin
            exp_hum = f[39:24];
            if (!m) exp_temp = f[23:8];
        end
        launch(f, m, -1);
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL %s_done: no DONE within budget", name); end
        if (chk_len) begin
            total++;
            if (start_len != START_US) begin bad++; $display("FAIL %s_start_len: got %0d want %0d", name, start_len, START_US); end
        end
        total++;
        if ({err, valid, raw} !== {want_err, 1'b1, f}) begin
            bad++; $display("FAIL %s_status: got err=%0d valid=%b raw=%h want err=%0d valid=1 raw=%h",
                            name, err, valid, raw, want_err, f);
        end
        total++;
        if ({hum, temp} !== {exp_hum, exp_temp}) begin
            bad++; $display("FAIL %s_data: got hum=%h temp=%h want hum=%h temp=%h", name, hum, temp, exp_hum, exp_temp);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL %s_done_width: got %b want 0", name, done); end
        wait_idle(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL %s_idle: busy=%b want 0", name, busy); end
    endtask

    task automatic test_dht22();
        exp_temp = 16'hFF9B;   // -10.1 C
        test_frame("dht22", 40'h028C806573, 1'b1, 2'd0, 1'b0);
    endtask

    task automatic test_bit_timeout();
        bit ok;
        int lows, n;
        launch(40'h3700190050, 1'b0, 20);
        wait_done(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_done: no DONE within budget"); end
        total++;
        if ({err, hum, temp} !== {2'd2, exp_hum, exp_temp}) begin
            bad++; $display("FAIL stall_result: got err=%0d hum=%h temp=%h want err=2 hum=%h temp=%h",
                            err, hum, temp, exp_hum, exp_temp);
        end
        lows = 0;
        for (int k = 0; k < 5; k++) begin
            repeat (100) begin @(negedge clk); if (dht_bus === 1'b0) lows++; end
            pulse_start(1'b0);
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL holdoff_busy_%0d: got %b want 1", k, busy); end
        end
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; if (dht_bus === 1'b0) lows++; end
        repeat (200) begin @(negedge clk); if (dht_bus === 1'b0) lows++; end
        total++;
        if (lows != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL holdoff_drop: got lows=%0d busy=%b want lows=0 busy=0", lows, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        launch(40'h3700190050, 1'b0, -1);
        n = 0;
        while (model_bit < 10 && n < 5000) begin @(negedge clk); n++; end
        total++;
        if (model_bit != 10) begin bad++; $display("FAIL rstmid_reach: got bit %0d want 10", model_bit); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({hum, temp, raw, busy, done, valid, err} !== 77'd0) begin
            bad++; $display("FAIL rstmid_outputs: got %h want 0", {hum, temp, raw, busy, done, valid, err});
        end
        model_abort = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // reset again while the start pulse is being driven
        pulse_start(1'b0);
        repeat (50) @(negedge clk);
        total++;
        if (dht_bus !== 1'b0) begin bad++; $display("FAIL rstlow_driving: got %b want 0", dht_bus); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (dht_bus !== 1'b1) begin bad++; $display("FAIL rstlow_release: got %b want 1", dht_bus); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        exp_hum = '0; exp_temp = '0;
        test_frame("after_rst", 40'h3700190050, 1'b0, 2'd0, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] b [4];
        logic [7:0] cs;
        logic [39:0] f;
        logic [1:0] want;
        bit m, ok, corrupt;
        int t, want_len;
        for (int it = 0; it < 3; it++) begin
            m = 1'($urandom_range(1, 0));
            for (int j = 0; j < 4; j++) b[j] = 8'($urandom_range(255, 0));
            cs = b[0] + b[1] + b[2] + b[3];
            corrupt = (it == 1);
            if (corrupt) cs = cs ^ 8'h01;
            f = {b[0], b[1], b[2], b[3], cs};
            want = corrupt ? 2'd3 : 2'd0;
            if (!corrupt) begin
                exp_hum = {b[0], b[1]};
                if (!m) begin
                    exp_temp = {b[2], b[3]};
                end else begin
                    t = int'(b[2] & 8'h7F) * 256 + int'(b[3]);
                    if (b[2][7]) t = -t;
                    exp_temp = t[15:0];
                end
            end
            want_len = START_US;
            launch(f, m, -1);
            if (it == 2) begin
                // pause mid start-pulse: the low time stretches by the pause
                repeat (100) @(negedge clk);
                en = 1'b0;
                repeat (200) @(negedge clk);
                en = 1'b1;
                want_len = START_US + 200;
            end
            wait_done(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL rand%0d_done: no DONE within budget", it); end
            total++;
            if (start_len != want_len) begin bad++; $display("FAIL rand%0d_start_len: got %0d want %0d", it, start_len, want_len); end
            total++;
            if ({err, valid, raw, hum, temp} !== {want, 1'b1, f, exp_hum, exp_temp}) begin
                bad++; $display("FAIL rand%0d_result: got err=%0d valid=%b raw=%h hum=%h temp=%h want err=%0d valid=1 raw=%h hum=%h temp=%h",
                                it, err, valid, raw, hum, temp, want, f, exp_hum, exp_temp);
            end
            wait_idle(ok);
            total++;
            if (!ok) begin bad++; $display("FAIL rand%0d_idle: busy=%b want 0", it, busy); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_no_response();
        test_frame("dht11", 40'h3700190050, 1'b0, 2'd0, 1'b1);
        test_dht22();
        test_frame("cksum", 40'h3700190051, 1'b0, 2'd3, 1'b0);
        test_bit_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
